// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO interrupt port: register offsets and default width.
package gpio_pkg;
    localparam int DEFAULT_WIDTH = 16;
    localparam int REG_COUNT     = 6;

    localparam logic [2:0] REG_IN       = 3'd0;
    localparam logic [2:0] REG_OUT      = 3'd1;
    localparam logic [2:0] REG_DIR      = 3'd2;
    localparam logic [2:0] REG_IRQ_EN   = 3'd3;
    localparam logic [2:0] REG_IRQ_STAT = 3'd4;
    localparam logic [2:0] REG_EDGE     = 3'd5;
endpackage

// File: rtl/gpio_irq_port_if.sv
// Register access bus of the GPIO port: strobed write/read, registered read return.
interface gpio_irq_port_if
    import gpio_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] addressbus;
    logic              wr_en;
    logic              rd_en;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;
    logic              rvalid;

    modport master (
        output addressbus, wr_en, rd_en, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  addressbus, wr_en, rd_en, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/gpio_sync2.sv
// Purpose: per-bit two-flop synchroniser for asynchronous pad inputs.
// Latency: 2 clk edges from d to q.
// Backpressure: none, free-running every cycle.
module gpio_sync2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/gpio_irq_port.sv
// Purpose: GPIO port with direction/output registers, edge-detect interrupts and W1C status.
// Latency: writes land on the strobe edge; reads return 1 cycle later; pad-to-IRQ_STAT 3 edges.
// Backpressure: none, one access accepted every cycle; rvalid is a single-cycle pulse.
module gpio_irq_port
    import gpio_pkg::*;
#(
    parameter int                WIDTH     = DEFAULT_WIDTH,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(4)
) (
    input  logic             clk,
    input  logic             reset,
    gpio_irq_port_if.slave   bus,
    inout  wire [WIDTH-1:0]  gpio_pins,
    output logic             irq
);
    logic [WIDTH-1:0]  out_q, dir_q, en_q, stat_q, edge_q, prev_q, rdata_q;
    logic [WIDTH-1:0]  sync_q, edge_set, stat_w1c, rd_mux;
    logic              rvalid_q;
    logic [ADDR_W-1:0] off;
    logic              hit;
    logic [2:0]        sel;
    logic              wr_out, wr_dir, wr_en_reg, wr_stat, wr_edge;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign gpio_pins[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    gpio_sync2 #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gpio_pins),
        .q     (sync_q)
    );

    // Addresses below the base wrap to large offsets and fall out of range.
    assign off = bus.addressbus - BASE_ADDR;
    assign hit = (bus.addressbus >= BASE_ADDR) && (off < ADDR_W'(REG_COUNT));
    assign sel = off[2:0];

    always_comb begin
        wr_out    = bus.wr_en && hit && (sel == REG_OUT);
        wr_dir    = bus.wr_en && hit && (sel == REG_DIR);
        wr_en_reg = bus.wr_en && hit && (sel == REG_IRQ_EN);
        wr_stat   = bus.wr_en && hit && (sel == REG_IRQ_STAT);
        wr_edge   = bus.wr_en && hit && (sel == REG_EDGE);
    end

    always_comb begin
        rd_mux = '0;
        if (hit) begin
            case (sel)
                REG_IN:       rd_mux = sync_q;
                REG_OUT:      rd_mux = out_q;
                REG_DIR:      rd_mux = dir_q;
                REG_IRQ_EN:   rd_mux = en_q;
                REG_IRQ_STAT: rd_mux = stat_q;
                REG_EDGE:     rd_mux = edge_q;
                default:      rd_mux = '0;
            endcase
        end
    end

    // Edge polarity per bit; OR-ing the set after the clear makes a new edge win over W1C.
    assign edge_set = (sync_q & ~prev_q & edge_q) | (~sync_q & prev_q & ~edge_q);
    assign stat_w1c = wr_stat ? bus.wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q    <= '0;
            dir_q    <= '0;
            en_q     <= '0;
            stat_q   <= '0;
            edge_q   <= '0;
            prev_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (wr_out)    out_q  <= bus.wdata;
            if (wr_dir)    dir_q  <= bus.wdata;
            if (wr_en_reg) en_q   <= bus.wdata;
            if (wr_edge)   edge_q <= bus.wdata;
            stat_q   <= (stat_q & ~stat_w1c) | edge_set;
            prev_q   <= sync_q;
            rvalid_q <= bus.rd_en;
            if (bus.rd_en) rdata_q <= rd_mux;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign irq        = |(stat_q & en_q);
endmodule
